// File: rtl/flag_register_unit.sv
// flag_register_unit
//   Status-flag block that sits behind the 8-bit ALU. It registers the ALU
//   C/Z results into the architectural flags and keeps shadow copies of C/Z
//   for interrupt entry and return. It also holds the interrupt-enable flag
//   and the external interrupt request path (synchronizer, rising-edge
//   detect, pending latch). The current flags drive the branch decision.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_c_in, i_z_in          ALU carry / zero results (combinational)
//   i_flg_c_ld/_set/_clr    C flag strobes (priority CLR > SET > LD)
//   i_flg_z_ld              Z flag load strobe
//   i_flg_ld_sel            load source: 0 = ALU, 1 = shadow (RETI)
//   i_i_set, i_i_clr        interrupt-enable set / clear
//   i_intr                  asynchronous level interrupt request
//   i_int_ack               one-cycle ISR entry pulse
//   i_br_cond               00 BRCS, 01 BRCC, 10 BREQ, 11 BRNE
//   o_c_flag, o_z_flag      registered flags (o_c_flag also feeds ALU CIN)
//   o_i_flag                interrupt enable
//   o_int_req               pending & enabled, combinational
//   o_br_take               branch decision from the registered flags
module flag_register_unit #(
  parameter int SYNC_STAGES = 2,    // legal range 2..4
  parameter bit I_RESET_VAL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_c_in,
  input  logic       i_z_in,
  input  logic       i_flg_c_ld,
  input  logic       i_flg_c_set,
  input  logic       i_flg_c_clr,
  input  logic       i_flg_z_ld,
  input  logic       i_flg_ld_sel,
  input  logic       i_i_set,
  input  logic       i_i_clr,
  input  logic       i_intr,
  input  logic       i_int_ack,
  input  logic [1:0] i_br_cond,
  output logic       o_c_flag,
  output logic       o_z_flag,
  output logic       o_i_flag,
  output logic       o_int_req,
  output logic       o_br_take
);

  logic                   r_c_flag, r_z_flag, r_i_flag;
  logic                   r_c_shadow, r_z_shadow;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_int_pend;

  logic w_c_src, w_z_src, w_sync_out, w_edge;

  // RETI restores from the shadow, normal ops load from the ALU.
  assign w_c_src    = i_flg_ld_sel ? r_c_shadow : i_c_in;
  assign w_z_src    = i_flg_ld_sel ? r_z_shadow : i_z_in;
  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_edge     = w_sync_out & ~r_hist;

  // Architectural flags and shadows. The shadow takes the pre-edge flag
  // value, so a load that coincides with INT_ACK is not lost on return.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c_flag   <= 1'b0;
      r_z_flag   <= 1'b0;
      r_c_shadow <= 1'b0;
      r_z_shadow <= 1'b0;
    end else begin
      if (i_flg_c_clr)      r_c_flag <= 1'b0;
      else if (i_flg_c_set) r_c_flag <= 1'b1;
      else if (i_flg_c_ld)  r_c_flag <= w_c_src;
      if (i_flg_z_ld)       r_z_flag <= w_z_src;
      if (i_int_ack) begin
        r_c_shadow <= r_c_flag;
        r_z_shadow <= r_z_flag;
      end
    end
  end

  // ISR entry masks interrupts and wins over any SEI/CLI in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_i_flag <= I_RESET_VAL;
    else if (i_int_ack) r_i_flag <= 1'b0;
    else if (i_i_clr)   r_i_flag <= 1'b0;
    else if (i_i_set)   r_i_flag <= 1'b1;
  end

  // Interrupt request path. A level held high makes a single edge pulse;
  // an edge arriving with INT_ACK re-sets the pending latch so it survives.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= '0;
      r_hist     <= 1'b0;
      r_int_pend <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_intr};
      r_hist     <= w_sync_out;
      r_int_pend <= w_edge | (r_int_pend & ~i_int_ack);
    end
  end

  always_comb begin
    o_br_take = 1'b0;
    case (i_br_cond)
      2'b00:   o_br_take =  r_c_flag;
      2'b01:   o_br_take = ~r_c_flag;
      2'b10:   o_br_take =  r_z_flag;
      default: o_br_take = ~r_z_flag;
    endcase
  end

  assign o_c_flag  = r_c_flag;
  assign o_z_flag  = r_z_flag;
  assign o_i_flag  = r_i_flag;
  assign o_int_req = r_int_pend & r_i_flag;

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed bench for flag_register_unit. Expected values are pushed to a
// scoreboard queue when stimulus is driven and popped/compared once the
// DUT has produced the result (after the edge, or immediately for
// combinational/asynchronous effects).
module tb_flag_register_unit;

  typedef enum logic [2:0] {S_C, S_Z, S_I, S_REQ, S_BR, S_PEND} sig_e;
  typedef struct {
    sig_e  sig;
    logic  exp;
    string tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c_in, z_in, c_ld, c_set, c_clr, z_ld, ld_sel;
  logic       i_set, i_clr, intr, int_ack;
  logic [1:0] br_cond;
  logic       c_flag, z_flag, i_flag, int_req, br_take;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  flag_register_unit #(.SYNC_STAGES(2), .I_RESET_VAL(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_c_in(c_in), .i_z_in(z_in),
    .i_flg_c_ld(c_ld), .i_flg_c_set(c_set), .i_flg_c_clr(c_clr),
    .i_flg_z_ld(z_ld), .i_flg_ld_sel(ld_sel), .i_i_set(i_set),
    .i_i_clr(i_clr), .i_intr(intr), .i_int_ack(int_ack),
    .i_br_cond(br_cond), .o_c_flag(c_flag), .o_z_flag(z_flag),
    .o_i_flag(i_flag), .o_int_req(int_req), .o_br_take(br_take)
  );

  always #5 clk = ~clk;

  function automatic logic observe(input sig_e s);
    case (s)
      S_C:     return c_flag;
      S_Z:     return z_flag;
      S_I:     return i_flag;
      S_REQ:   return int_req;
      S_BR:    return br_take;
      default: return dut.r_int_pend;
    endcase
  endfunction

  task automatic push(input sig_e s, input logic e, input string tag);
    exp_t x;
    x.sig = s; x.exp = e; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    logic o;
    while (q.size() > 0) begin
      x = q.pop_front();
      o = observe(x.sig);
      checks++;
      assert (o === x.exp) else begin
        errors++;
        $error("FAIL %s observed=%0b expected=%0b", x.tag, o, x.exp);
      end
    end
  endtask

  // Rising edge, compare, then return at the falling edge ready to drive.
  task automatic step();
    @(posedge clk); #1;
    drain();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic strobes_off();
    c_ld = 0; c_set = 0; c_clr = 0; z_ld = 0; ld_sel = 0;
    i_set = 0; i_clr = 0; int_ack = 0;
  endtask

  initial begin
    rst_n = 0; c_in = 0; z_in = 0; intr = 0; br_cond = 2'b01;
    strobes_off();

    // Reset state
    @(negedge clk); #1;
    push(S_C, 0, "rst_c"); push(S_Z, 0, "rst_z"); push(S_I, 0, "rst_i");
    push(S_REQ, 0, "rst_req"); push(S_PEND, 0, "rst_pend");
    push(S_BR, 1, "rst_brcc");
    drain();
    @(negedge clk);
    rst_n = 1;
    step();

    // ALU load, then branch decode on the registered flags
    c_in = 1; z_in = 0; c_ld = 1; z_ld = 1;
    push(S_C, 1, "ld_c"); push(S_Z, 0, "ld_z");
    step();
    strobes_off(); c_in = 0; z_in = 1;   // ALU changes must not affect BR_TAKE
    br_cond = 2'b00; #1; push(S_BR, 1, "brcs"); drain();
    br_cond = 2'b11; #1; push(S_BR, 1, "brne"); drain();
    br_cond = 2'b10; #1; push(S_BR, 0, "breq"); drain();
    br_cond = 2'b01; #1; push(S_BR, 0, "brcc"); drain();
    push(S_Z, 0, "z_hold");
    step();

    // C force priority
    c_set = 1; c_clr = 1; c_ld = 1; c_in = 1;
    push(S_C, 0, "clr_wins");
    step();
    c_clr = 0; c_in = 0;
    push(S_C, 1, "set_over_ld");
    step();
    strobes_off();

    // Interrupt latency with I enabled
    i_set = 1; push(S_I, 1, "sei"); step();
    strobes_off();
    intr = 1;
    push(S_REQ, 0, "lat_e1"); step();
    push(S_REQ, 0, "lat_e2"); step();
    push(S_REQ, 1, "lat_e3"); step();
    idle(7);
    push(S_REQ, 1, "req_held"); step();
    int_ack = 1;
    push(S_PEND, 0, "ack_pend"); push(S_I, 0, "ack_i"); push(S_REQ, 0, "ack_req");
    step();
    strobes_off();
    idle(4);
    i_set = 1;
    push(S_I, 1, "sei2"); push(S_REQ, 0, "level_once");
    step();
    strobes_off();
    intr = 0;
    idle(4);

    // Shadow round trip; ISR-entry load coincides with INT_ACK
    c_in = 1; z_in = 1; c_ld = 1; z_ld = 1;
    push(S_C, 1, "pre_c"); push(S_Z, 1, "pre_z");
    step();
    c_in = 0; z_in = 0; int_ack = 1;
    push(S_C, 0, "isr_c"); push(S_Z, 0, "isr_z"); push(S_I, 0, "isr_i");
    step();
    strobes_off();
    c_ld = 1; z_ld = 1; ld_sel = 1; i_set = 1; c_in = 0; z_in = 0;
    push(S_C, 1, "reti_c"); push(S_Z, 1, "reti_z"); push(S_I, 1, "reti_i");
    step();
    strobes_off();

    // Edge pulse coinciding with INT_ACK; I_SET loses to INT_ACK
    intr = 1;
    idle(2);
    int_ack = 1; i_set = 1;
    push(S_PEND, 1, "edge_ack_pend"); push(S_I, 0, "ack_over_sei");
    push(S_REQ, 0, "edge_ack_req");
    step();
    strobes_off();
    int_ack = 1; push(S_PEND, 0, "clear_pend"); step();
    strobes_off();

    // Masked request: pending while I=0, then enabled
    intr = 0; idle(4);
    intr = 1; idle(2);
    push(S_PEND, 1, "mask_pend"); push(S_REQ, 0, "mask_req");
    step();
    i_set = 1;
    push(S_REQ, 1, "unmask_req");
    step();
    strobes_off();

    // Asynchronous reset mid-cycle with flags=1 and a pending request
    c_in = 1; z_in = 1; c_ld = 1; z_ld = 1;
    push(S_C, 1, "pre_rst_c"); push(S_Z, 1, "pre_rst_z");
    step();
    strobes_off();
    push(S_PEND, 1, "pre_rst_pend"); drain();
    #2 rst_n = 0; #1;
    push(S_C, 0, "arst_c"); push(S_Z, 0, "arst_z"); push(S_PEND, 0, "arst_pend");
    push(S_REQ, 0, "arst_req"); push(S_I, 0, "arst_i"); push(S_BR, 1, "arst_brcc");
    drain();
    @(negedge clk);
    rst_n = 1;
    intr = 0;
    // Shadow was cleared by reset: RETI restores zeros
    c_ld = 1; z_ld = 1; ld_sel = 1;
    push(S_C, 0, "rst_shadow_c"); push(S_Z, 0, "rst_shadow_z");
    step();
    strobes_off();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
